// File: rtl/rps_pkg.sv
// rps_pkg: shared types, sizes and helpers for the rotating-priority requester front end
package rps_pkg;
  localparam int NUM_REQ = 4;
  localparam int RPS_DEPTH = 3;
  localparam int RPS_HOLD_CYCLES = 2;
  typedef enum logic [0:0] {RC_IDLE, RC_HOLD} rc_state_e;
  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction
endpackage

// File: rtl/rps_pend_ctr.sv
// rps_pend_ctr: saturating pending-request counter for one client with sticky overflow
module rps_pend_ctr #(
  parameter int DEPTH = 3,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  output logic [CNT_W-1:0] cnt,
  output logic             overflow
);
  logic full;
  assign full = cnt == CNT_W'(DEPTH);
  // push and pop together cancel out, so a full counter never overflows on a simultaneous pop
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      overflow <= 1'b0;
    end else if (push && !pop) begin
      cnt <= full ? cnt : cnt + 1'b1;
      overflow <= overflow | full;
    end else if (pop && !push) begin
      cnt <= cnt - 1'b1;
    end
  end
  a_no_pop_at_zero: assert property (@(posedge clock) disable iff (reset) !(pop && cnt == '0));
endmodule

// File: rtl/rps_req_client.sv
// rps_req_client: per-client request queueing, selector handshake and fixed-length bus ownership
module rps_req_client
  import rps_pkg::*;
#(
  parameter int DEPTH = RPS_DEPTH,
  parameter int HOLD_CYCLES = RPS_HOLD_CYCLES,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       push,
  input  logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       req,
  output logic                     en,
  output logic [NUM_REQ-1:0]       owner,
  output logic                     busy,
  output logic                     done,
  output logic [NUM_REQ*CNT_W-1:0] pend,
  output logic [NUM_REQ-1:0]       overflow,
  output logic                     gnt_err
);
  localparam int TW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  rc_state_e state, state_n;
  logic [NUM_REQ-1:0] owner_n, pop, nz;
  logic [TW-1:0] timer, timer_n;
  logic idle, legal;
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_ctr
    rps_pend_ctr #(.DEPTH(DEPTH)) u_ctr (
      .clock(clock),
      .reset(reset),
      .push(push[i]),
      .pop(pop[i]),
      .cnt(pend[i*CNT_W +: CNT_W]),
      .overflow(overflow[i])
    );
    assign nz[i] = |pend[i*CNT_W +: CNT_W];
  end
  assign idle = state == RC_IDLE;
  assign req = idle ? nz : '0;
  assign en = |req;
  assign legal = en && is_onehot4(gnt) && ((gnt & ~req) == '0);
  assign gnt_err = idle && (gnt != '0) && !legal;
  assign busy = !idle;
  assign done = !idle && (timer == '0);
  assign pop = done ? owner : '0;
  // next state: a legal grant opens a HOLD window, the final HOLD cycle returns to IDLE
  always_comb begin
    state_n = idle ? (legal ? RC_HOLD : RC_IDLE) : (done ? RC_IDLE : RC_HOLD);
    owner_n = idle ? (legal ? gnt : '0) : (done ? '0 : owner);
    timer_n = idle ? TW'(HOLD_CYCLES - 1) : (done ? '0 : timer - 1'b1);
  end
  // state, owner and hold timer registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= RC_IDLE;
      owner <= '0;
      timer <= '0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      timer <= timer_n;
    end
  end
endmodule

// File: tb/tb_rps_req_client.sv
// tb_rps_req_client: vector table plus scoreboarded rotation test for rps_req_client
module tb_rps_req_client;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [3:0] push = '0, gnt = '0;
  logic [3:0] req, owner, overflow;
  logic en, busy, done, gnt_err;
  logic [7:0] pend;
  int n_cmp = 0, n_bad = 0;
  typedef struct {
    logic [3:0] push, gnt, req;
    logic en;
    logic [3:0] owner;
    logic busy, done, err;
    logic [7:0] pend;
    logic [3:0] ovf;
  } vec_t;
  vec_t tbl[19];
  logic [3:0] sb[$];

  always #5 clock = ~clock;

  rps_req_client dut (
    .clock(clock), .reset(reset), .push(push), .gnt(gnt), .req(req), .en(en),
    .owner(owner), .busy(busy), .done(done), .pend(pend), .overflow(overflow), .gnt_err(gnt_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic cycle(input logic [3:0] p, input logic [3:0] g);
    @(negedge clock);
    push = p;
    gnt = g;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    push = '0;
    gnt = '0;
    #1;
    chk("rst_pend", pend, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{4'b0001, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00, 4'b0000};
    tbl[1]  = '{4'b0000, 4'b0001, 4'b0001, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h01, 4'b0000};
    tbl[2]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 8'h01, 4'b0000};
    tbl[3]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0001, 1'b1, 1'b1, 1'b0, 8'h01, 4'b0000};
    tbl[4]  = '{4'b0000, 4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 8'h00, 4'b0000};
    tbl[5]  = '{4'b0001, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00, 4'b0000};
    tbl[6]  = '{4'b0000, 4'b0011, 4'b0001, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 8'h01, 4'b0000};
    tbl[7]  = '{4'b0000, 4'b0100, 4'b0001, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 8'h01, 4'b0000};
    tbl[8]  = '{4'b0000, 4'b0000, 4'b0001, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h01, 4'b0000};
    tbl[9]  = '{4'b0000, 4'b0001, 4'b0001, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h01, 4'b0000};
    tbl[10] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 8'h01, 4'b0000};
    tbl[11] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0001, 1'b1, 1'b1, 1'b0, 8'h01, 4'b0000};
    tbl[12] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00, 4'b0000};
    tbl[13] = '{4'b0100, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00, 4'b0000};
    tbl[14] = '{4'b0100, 4'b0000, 4'b0100, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h10, 4'b0000};
    tbl[15] = '{4'b0100, 4'b0000, 4'b0100, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h20, 4'b0000};
    tbl[16] = '{4'b0100, 4'b0000, 4'b0100, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h30, 4'b0000};
    tbl[17] = '{4'b0101, 4'b0000, 4'b0100, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h30, 4'b0100};
    tbl[18] = '{4'b0000, 4'b0000, 4'b0101, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h31, 4'b0100};
    #1;
    chk("rst_req", req, 0);
    chk("rst_en", en, 0);
    chk("rst_done", done, 0);
    chk("rst_err", gnt_err, 0);
    do_reset();
    // single grant, illegal grants, saturation
    for (int r = 0; r < 19; r++) begin
      cycle(tbl[r].push, tbl[r].gnt);
      chk($sformatf("v%0d_req", r), req, tbl[r].req);
      chk($sformatf("v%0d_en", r), en, tbl[r].en);
      chk($sformatf("v%0d_owner", r), owner, tbl[r].owner);
      chk($sformatf("v%0d_busy", r), busy, tbl[r].busy);
      chk($sformatf("v%0d_done", r), done, tbl[r].done);
      chk($sformatf("v%0d_err", r), gnt_err, tbl[r].err);
      chk($sformatf("v%0d_pend", r), pend, tbl[r].pend);
      chk($sformatf("v%0d_ovf", r), overflow, tbl[r].ovf);
    end
    do_reset();
    // reset asserted on the second HOLD cycle aborts the transaction
    cycle(4'b0001, 4'b0000);
    cycle(4'b0001, 4'b0001);
    chk("mid_en", en, 1);
    cycle(4'b0000, 4'b0000);
    chk("mid_busy1", busy, 1);
    chk("mid_done1", done, 0);
    cycle(4'b0000, 4'b0000);
    chk("mid_busy2", busy, 1);
    chk("mid_pend2", pend, 8'h02);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_owner", owner, 0);
    chk("mid_rst_pend", pend, 0);
    chk("mid_rst_req", {req, en}, 0);
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle(4'b0000, 4'b0000);
      chk("mid_after_done", done, 0);
      chk("mid_after_pend", pend, 0);
    end
    // push and pop on the same full client cancel
    repeat (3) cycle(4'b0010, 4'b0000);
    cycle(4'b0000, 4'b0010);
    chk("pp_req", req, 4'b0010);
    chk("pp_pend_full", pend, 8'h0C);
    cycle(4'b0000, 4'b0000);
    chk("pp_busy", busy, 1);
    cycle(4'b0010, 4'b0000);
    chk("pp_done", done, 1);
    cycle(4'b0000, 4'b0000);
    chk("pp_pend", pend, 8'h0C);
    chk("pp_ovf", overflow, 0);
    chk("pp_idle", busy, 0);
    do_reset();
    // full rotation against a rotating-priority selector stub
    cycle(4'b1111, 4'b0000);
    begin
      int dones = 0, ptr = 0, busy_run = 0;
      logic prev_done = 1'b0;
      logic [3:0] g;
      for (int c = 0; c < 60 && dones < 4; c++) begin
        @(negedge clock);
        push = '0;
        g = '0;
        if (en) begin
          for (int k = 0; k < 4; k++) begin
            if (g == '0 && req[(ptr + k) % 4]) begin
              g[(ptr + k) % 4] = 1'b1;
              ptr = (ptr + k + 1) % 4;
            end
          end
        end
        gnt = g;
        if (g != '0) sb.push_back(g);
        #1;
        chk("rot_err", gnt_err, 0);
        if (prev_done) begin
          chk("rot_gap_busy", busy, 0);
          chk("rot_gap_en", en, 1);
        end
        if (busy) busy_run++;
        if (done) begin
          chk("rot_hold_len", busy_run, 2);
          busy_run = 0;
          chk("rot_order", owner, 32'(4'b0001 << dones));
          if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rot_sb: got done want queued grant");
          end else begin
            chk("rot_owner", owner, sb.pop_front());
          end
          dones++;
        end
        prev_done = done;
      end
      chk("rot_dones", dones, 4);
    end
    cycle(4'b0000, 4'b0000);
    chk("rot_pend", pend, 0);
    chk("rot_req", req, 0);
    chk("rot_sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rps_req_client.md
Name: rps_req_client

Overview:
- Requester-side front end for the 4-way rotating priority selector.
- Accepts request pulses from four clients and keeps a bounded pending-request count per client.
- Drives the selector's req/en inputs, samples its one-hot gnt, then holds the granted client as bus owner for a fixed number of cycles.
- Retires one pending request per completed grant.

Parameters:
- NUM_REQ, 4: number of clients; the selector width is fixed, so only 4 is supported.
- DEPTH, 3: maximum pending requests per client.
- CNT_W, $clog2(DEPTH+1) = 2: width of each pending counter.
- HOLD_CYCLES, 2: bus-ownership cycles per grant; must be >= 1.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- push  input  NUM_REQ  push[i]=1 posts one request for client i this cycle.
- gnt  input  NUM_REQ  grant vector from the selector, combinational from req.
- req  output  NUM_REQ  request vector to the selector.
- en  output  1  selector enable.
- owner  output  NUM_REQ  one-hot current bus owner; 0 when idle.
- busy  output  1  1 while in HOLD.
- done  output  1  one-cycle pulse on the last HOLD cycle.
- pend  output  NUM_REQ*CNT_W  flattened pending counts; client i occupies bits [i*CNT_W +: CNT_W].
- overflow  output  NUM_REQ  sticky: a push was dropped because client i was full.
- gnt_err  output  1  one-cycle pulse: illegal gnt seen in IDLE.

Behaviour:
Reset values:
- All outputs 0, state IDLE, all pend 0, timer 0.
- Reset asserted mid-HOLD aborts the transaction: no done pulse, no decrement.

States: IDLE, HOLD.

IDLE:
- req[i] = (pend[i] != 0).
- en = |req.
- owner = 0, busy = 0.
- gnt is legal when it is one-hot, a subset of req, and en=1.
- Legal gnt at cycle t:
  - owner <= gnt, timer <= HOLD_CYCLES-1, state <= HOLD.
  - busy=1 in cycles t+1 .. t+HOLD_CYCLES.
- gnt == 0: stay IDLE, no error.
- Any other nonzero gnt (multi-hot, or grant to a non-requester): stay IDLE, gnt_err=1 for that cycle, no state change.

HOLD:
- req = 0, en = 0, gnt ignored.
- Timer decrements each cycle.
- When timer == 0:
  - done=1 that cycle.
  - pend[owner] decrements at the edge.
  - state <= IDLE, owner <= 0.
- HOLD_CYCLES=1: done in the first HOLD cycle.
- Back-to-back grants: earliest next grant is the cycle after done; there is no bubble beyond that.

Pending counters (saturating, per client):
- push without pop: +1 if pend < DEPTH; else drop the push and set overflow[i].
- pop without push: -1. A pop at 0 cannot occur; it is an assertion-checked invariant.
- push and pop on the same client in the same cycle: pend unchanged, no overflow, even if pend == DEPTH.
- Pushes to any client are accepted in every state, including HOLD.

Other rules:
- overflow bits clear only on reset.
- No combinational path from push to req: req depends on registered pend and state only. This avoids a loop through the selector.

Decomposition:
- Shared package rps_pkg holds:
  - typedef enum logic [0:0] {RC_IDLE, RC_HOLD} rc_state_e
  - localparam NUM_REQ = 4
  - function is_onehot4
- Natural sub-module: rps_pend_ctr, one saturating up/down counter with push, pop, full, overflow. Instantiate it four times.
- FSM and timer stay in the top module.

Test Plan:
- Reset mid-HOLD: push[0]=1 for 2 cycles, stub gnt=4'b0001 in the first en cycle, assert reset on the 2nd busy cycle -> all outputs 0 immediately, done never pulses, pend all 0.
- Single grant: push[0] once, pend[0]=1, stub gnt=4'b0001 when en=1 -> busy=1 for exactly 2 cycles, owner=4'b0001, done pulses on the 2nd, pend[0]=0 afterwards, req=0.
- Full rotation with real rps4 connected: push all four clients once -> four grants in the selector's rotation order, four done pulses with exactly one IDLE cycle between HOLD periods, final pend all 0, gnt_err never 1.
- Saturation: push[2] for 5 consecutive cycles with no grant -> pend[2]=3, overflow=4'b0100 sticky; pushes to other clients unaffected.
- Simultaneous push/pop: pend[1]=3, grant client 1, push[1]=1 in the done cycle -> pend[1] stays 3, overflow[1] stays 0.
- Illegal grants: pend[0]=1, drive gnt=4'b0011, then gnt=4'b0100 -> gnt_err pulses each time, state stays IDLE, pend unchanged; a legal gnt=4'b0001 then proceeds normally.
